// File: rtl/uart_defs.sv
// Shared UART definitions: TX frame FSM states, framing enums and the
// per-frame configuration that is latched when a frame starts.
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } TXFrameState_t;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } Parity_t;

  typedef enum logic [1:0] {
    DBITS_5 = 2'b00,
    DBITS_6 = 2'b01,
    DBITS_7 = 2'b10,
    DBITS_8 = 2'b11
  } DataBits_t;

  typedef struct packed {
    DataBits_t data_bits;
    Parity_t   parity;
    logic      stop2;
  } TXFrameCfg_t;

  // Index of the last data bit (4..7 for 5..8 data bits).
  function automatic logic [2:0] last_data_idx(DataBits_t n);
    return 3'd4 + {1'b0, n};
  endfunction

  function automatic logic parity_en(Parity_t p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

  function automatic logic parity_bit(logic [7:0] d, DataBits_t n, Parity_t p);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - n);
    return (p == PAR_ODD) ^ (^(d & mask));
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with synchronous flush and occupancy output.
// Pointers carry one extra bit so full and empty are distinguishable.
module fifo_sync #(
  parameter int unsigned data_size   = 8,
  parameter int unsigned buffer_size = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [data_size-1:0]         wdata_i,
  input  logic                         pop_i,
  output logic [data_size-1:0]         rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(buffer_size):0] level_o
);

  localparam int unsigned AW = $clog2(buffer_size);

  logic [data_size-1:0] mem_q [buffer_size];
  logic [AW:0]          wr_q;
  logic [AW:0]          rd_q;
  logic                 push_ok;
  logic                 pop_ok;

  // A write is dropped while full even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o;

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == (AW+1)'(buffer_size));
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: TX FIFO, baud divider, configurable framing,
// RTS/CTS flow control, break generation and per-frame interrupts.
module uart_tx_frame
  import uart_defs::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_d_i,
  input  logic                        tx_d_valid_i,
  output logic                        tx_d_ready_o,
  output logic                        tx_full_o,
  output logic                        tx_empty_o,
  output logic [$clog2(FIFO_DEPTH):0] tx_level_o,
  input  logic                        flush_i,
  input  logic [DIV_W-1:0]            cfg_div_i,
  input  logic [1:0]                  cfg_data_bits_i,
  input  logic [1:0]                  cfg_parity_i,
  input  logic                        cfg_stop2_i,
  input  logic                        cfg_flow_en_i,
  input  logic                        tx_enable_i,
  input  logic                        tx_break_i,
  input  logic                        tx_cts_n_i,
  output logic                        tx_q_o,
  output logic                        tx_rts_n_o,
  output logic                        tx_busy_o,
  output logic                        irq_done_o,
  output logic                        irq_empty_o
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  TXFrameState_t    state_q;
  TXFrameCfg_t      cfg_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [7:0]       shr_q;
  logic             par_q;
  logic [2:0]       bit_idx_q;
  logic             stop_idx_q;
  logic             brk_rel_q;
  logic             tx_q_q;
  logic             rts_n_q;
  logic             irq_done_q;
  logic             irq_empty_q;

  logic [7:0]       fifo_dout;
  logic             pop;
  logic             push_acc;
  logic             start_ok;
  logic             bit_end;
  logic             stop_last;
  logic             frame_active;
  logic             line;

  fifo_sync #(
    .data_size   (8),
    .buffer_size (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .push_i  (tx_d_valid_i),
    .wdata_i (tx_d_i),
    .pop_i   (pop),
    .rdata_o (fifo_dout),
    .full_o  (tx_full_o),
    .empty_o (tx_empty_o),
    .level_o (tx_level_o)
  );

  assign start_ok     = !tx_empty_o && tx_enable_i && !tx_break_i &&
                        (!cfg_flow_en_i || !tx_cts_n_i);
  assign bit_end      = (cnt_q == '0);
  assign stop_last    = !cfg_q.stop2 || stop_idx_q;
  assign frame_active = (state_q != ST_IDLE) && (state_q != ST_BREAK);
  assign push_acc     = tx_d_valid_i && !tx_full_o && !flush_i;

  // Frames start from IDLE or chain directly off the last stop bit, so
  // back-to-back frames leave no idle cycle on the line.
  always_comb begin
    pop = 1'b0;
    if (state_q == ST_IDLE && start_ok) pop = 1'b1;
    if (state_q == ST_STOP && bit_end && stop_last && start_ok) pop = 1'b1;
  end

  always_comb begin
    line = 1'b1;
    case (state_q)
      ST_IDLE:   line = 1'b1;
      ST_START:  line = 1'b0;
      ST_DATA:   line = shr_q[0];
      ST_PARITY: line = par_q;
      ST_STOP:   line = 1'b1;
      ST_BREAK:  line = brk_rel_q;
      default:   line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '{data_bits: DBITS_8, parity: PAR_NONE, stop2: 1'b0};
      div_q       <= '0;
      cnt_q       <= '0;
      shr_q       <= '0;
      par_q       <= 1'b0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      brk_rel_q   <= 1'b0;
      tx_q_q      <= 1'b1;
      rts_n_q     <= 1'b1;
      irq_done_q  <= 1'b0;
      irq_empty_q <= 1'b0;
    end else begin
      tx_q_q      <= line;
      rts_n_q     <= !(cfg_flow_en_i && (!tx_empty_o || frame_active));
      irq_done_q  <= 1'b0;
      irq_empty_q <= pop && (tx_level_o == LVL_W'(1)) && !push_acc;

      case (state_q)
        ST_IDLE: begin
          if (tx_break_i) begin
            state_q   <= ST_BREAK;
            brk_rel_q <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q   <= ST_DATA;
            cnt_q     <= div_q;
            bit_idx_q <= '0;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_q <= div_q;
            shr_q <= shr_q >> 1;
            if (bit_idx_q == last_data_idx(cfg_q.data_bits)) begin
              state_q    <= parity_en(cfg_q.parity) ? ST_PARITY : ST_STOP;
              stop_idx_q <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_q    <= ST_STOP;
            cnt_q      <= div_q;
            stop_idx_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop_last) begin
              irq_done_q <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              stop_idx_q <= 1'b1;
              cnt_q      <= div_q;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        ST_BREAK: begin
          if (!brk_rel_q) begin
            if (!tx_break_i) begin
              brk_rel_q <= 1'b1;
              div_q     <= cfg_div_i;
              cnt_q     <= cfg_div_i;
            end
          end else if (bit_end) begin
            state_q   <= ST_IDLE;
            brk_rel_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Frame launch overrides the case above (IDLE or final stop bit).
      if (pop) begin
        state_q <= ST_START;
        cfg_q   <= '{data_bits: DataBits_t'(cfg_data_bits_i),
                     parity:    Parity_t'(cfg_parity_i),
                     stop2:     cfg_stop2_i};
        div_q   <= cfg_div_i;
        cnt_q   <= cfg_div_i;
        shr_q   <= fifo_dout;
        par_q   <= parity_bit(fifo_dout, DataBits_t'(cfg_data_bits_i),
                              Parity_t'(cfg_parity_i));
      end
    end
  end

  assign tx_q_o       = tx_q_q;
  assign tx_rts_n_o   = rts_n_q;
  assign tx_busy_o    = (state_q != ST_IDLE);
  assign irq_done_o   = irq_done_q;
  assign irq_empty_o  = irq_empty_q;
  assign tx_d_ready_o = !tx_full_o;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised single-clock UART transmitter with an internal baud-rate divider, a synchronous TX FIFO, and runtime-configurable framing. Supported framing is 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits. It adds RTS/CTS flow control, break generation and per-frame interrupt pulses. It sits in the UART peripheral between the register bank (config, TX data writes) and the pad driver.

## Interface
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2
- DIV_W, 16, width of baud divisor
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- tx_d_i  in  8  write data; bits above active data width ignored
- tx_d_valid_i  in  1  write strobe; accepted when tx_d_ready_o=1
- tx_d_ready_o  out  1  !tx_full_o
- tx_full_o / tx_empty_o  out  1  FIFO status
- tx_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- flush_i  in  1  empty FIFO
- cfg_div_i  in  DIV_W  bit period = cfg_div_i+1 clk cycles
- cfg_data_bits_i  in  2  00=5, 01=6, 10=7, 11=8 data bits
- cfg_parity_i  in  2  00 none, 01 even, 10 odd, 11 none
- cfg_stop2_i  in  1  1 = two stop bits
- cfg_flow_en_i  in  1  enable RTS/CTS
- tx_enable_i  in  1  permit new frames
- tx_break_i  in  1  request break
- tx_cts_n_i  in  1  clear-to-send, active-low
- tx_q_o  out  1  serial line, registered, idles high
- tx_rts_n_o  out  1  request-to-send, active-low, registered
- tx_busy_o  out  1  state ≠ IDLE
- irq_done_o  out  1  1-cycle pulse at end of last stop bit
- irq_empty_o  out  1  1-cycle pulse when a pop leaves FIFO empty

## Operation
- Reset values: tx_q_o=1, tx_rts_n_o=1, tx_busy_o=0, irq_*=0, FIFO empty (tx_empty_o=1, tx_level_o=0), state IDLE.
- Frame bit order: start(0), data LSB first, optional parity, stop(1) ×1 or ×2.
- Frame length: 1+N+P+S bits.
- Parity is computed over active data bits only. Even parity: bit = XOR of data. Odd parity: bit = inverted XOR.
- Config (div, data bits, parity, stop2) is latched at frame start. Changes mid-frame take effect on the next frame.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE→START when all hold: FIFO non-empty, tx_enable_i=1, tx_break_i=0, and (cfg_flow_en_i=0 or tx_cts_n_i=0). The FIFO pops in the same cycle.
- START→DATA after one bit period.
- DATA→PARITY after N bits if parity is enabled, otherwise DATA→STOP.
- PARITY→STOP after one bit period.
- STOP→IDLE after S bit periods; irq_done_o pulses on that transition.
- IDLE→BREAK when tx_break_i=1. In BREAK, tx_q_o=0 while tx_break_i is held.
- On break release, the line drives 1 for one full bit period, then returns to IDLE. A break requested mid-frame waits for frame end.
- Baud counter loads cfg_div_i at each bit start and decrements. The bit ends on the cycle the counter reaches 0. div=0 gives 1 clk per bit.
- RTS: with cfg_flow_en_i=1, tx_rts_n_o=0 while FIFO non-empty or a frame is in progress. With cfg_flow_en_i=0, tx_rts_n_o=1 and CTS is ignored.
- CTS is sampled only at frame start. CTS deassertion mid-frame never aborts a frame.
- tx_enable_i=0 blocks new frames only; the current frame completes.
- flush_i clears the FIFO the next cycle. The frame in progress completes; a write in the flush cycle is dropped.
- Write while full is dropped, even if a pop occurs in the same cycle. FIFO pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop when neither full nor empty: tx_level_o is unchanged.

## Timing
- A write at edge E into an empty FIFO, with state IDLE and conditions met, makes tx_q_o go 0 after edge E+2.
- Each bit holds tx_q_o for exactly cfg_div_i+1 cycles.
- Back-to-back frames have no idle gap: next start follows the last stop immediately if the FIFO is non-empty.
- Asynchronous rst mid-frame: outputs return to reset values immediately and the FIFO is emptied.

## Structure
- Package uart_defs gains TXFrameState_t (the six states), Parity_t, DataBits_t, and TXFrameCfg_t (latched config struct).
- Sub-module fifo_sync (single clock, parameter data_size, buffer_size, flush, level output), reusable by the RX side.

## Test plan
- div=3, 8N1, write 0xA5 → tx_q_o: 0,1,0,1,0,0,1,0,1,1, each 4 cycles; irq_done_o one pulse; irq_empty_o one pulse.
- div=0, 7E2, write 0x55 → bits 0,1010101,0(parity),1,1; tx_busy_o high for exactly 11 cycles.
- 5O1, write 0xFF → data 11111, parity 0; upper bits ignored.
- Fill 8 entries, write a 9th → dropped, tx_level_o=8; all 8 frames sent back-to-back, no gap.
- Flow enabled, tx_cts_n_i=1, one entry queued → tx_rts_n_o=0, tx_q_o stays 1. Drop CTS → frame starts. Raise CTS mid-frame → frame completes.
- tx_break_i asserted mid-frame → frame finishes, then tx_q_o=0 until release, then 1 for div+1 cycles. Assert rst mid-frame → tx_q_o=1 immediately, tx_empty_o=1.
